step_pair_engine: RTL

//   Parametrised, bounded step engine for a coupled (x, y) counter pair.
//   On each step, x moves by X_STEP and y moves by Y_STEP, either up or down.

---
 rtl/step_pair_engine.sv | 137 +++++++++++++
 1 files changed

// File: rtl/step_pair_engine.sv
// Purpose : bounded step engine for a coupled (x, y) counter pair with a wrap
//           or saturate overflow policy, a start/busy/done run FSM and a
//           built-in invariant monitor.
// Latency : start/sel sampled at posedge clk; x, y, iter and all flags update
//           at that edge. Results are visible one cycle after the input is
//           driven. There is no combinational path from sel to x/y.
// Backpres: none. A step requested in IDLE or DONE is dropped silently. With
//           SAT=1, a step that would carry or borrow is dropped and flagged on
//           blocked.
// Ports   : clk, rst (sync active-high); start, sel[1:0] (01 up, 10 down);
//           x, y [W-1:0]; iter (applied steps in this run); busy (RUN);
//           done (DONE level); blocked (1-cycle pulse); inv_ok (comb).
module step_pair_engine #(
  parameter int W        = 10,
  parameter int X_INIT   = 2,
  parameter int Y_INIT   = 0,
  parameter int X_STEP   = 2,
  parameter int Y_STEP   = 1,
  parameter int MAX_ITER = 16,
  parameter bit SAT      = 1'b0,
  localparam int IW      = $clog2(MAX_ITER + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [1:0]    sel,
  output logic [W-1:0]  x,
  output logic [W-1:0]  y,
  output logic [IW-1:0] iter,
  output logic          busy,
  output logic          done,
  output logic          blocked,
  output logic          inv_ok
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  x_q, x_d;
  logic [W-1:0]  y_q, y_d;
  logic [W-1:0]  k_q, k_d;
  logic [IW-1:0] iter_q, iter_d;
  logic          blocked_q, blocked_d;

  // W+1-bit sums: the top bit is the carry (up) or borrow (down) out of bit W-1.
  logic [W:0] x_up, y_up, x_dn, y_dn;
  logic       step_up, step_dn, ovf, step_apply;

  always_comb begin
    x_up = {1'b0, x_q} + (W+1)'(X_STEP);
    y_up = {1'b0, y_q} + (W+1)'(Y_STEP);
    x_dn = {1'b0, x_q} - (W+1)'(X_STEP);
    y_dn = {1'b0, y_q} - (W+1)'(Y_STEP);
    // start beats sel, so a step is only requested in RUN without start.
    step_up = (state_q == S_RUN) && !start && (sel == 2'b01);
    step_dn = (state_q == S_RUN) && !start && (sel == 2'b10);
    ovf     = (step_up && (x_up[W] || y_up[W])) ||
              (step_dn && (x_dn[W] || y_dn[W]));
    // Under SAT the whole pair step is dropped if either coordinate overflows.
    step_apply = (step_up || step_dn) && !(SAT && ovf);
  end

  // Datapath next-state.
  always_comb begin
    x_d       = x_q;
    y_d       = y_q;
    k_d       = k_q;
    iter_d    = iter_q;
    blocked_d = 1'b0;
    if (start) begin
      x_d    = W'(X_INIT);
      y_d    = W'(Y_INIT);
      k_d    = '0;
      iter_d = '0;
    end else if (step_apply) begin
      x_d    = step_up ? x_up[W-1:0] : x_dn[W-1:0];
      y_d    = step_up ? y_up[W-1:0] : y_dn[W-1:0];
      k_d    = step_up ? k_q + W'(1) : k_q - W'(1);
      iter_d = iter_q + IW'(1);
    end else if (step_up || step_dn) begin
      blocked_d = 1'b1;
    end
  end

  // FSM: state register plus all datapath flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      x_q       <= W'(X_INIT);
      y_q       <= W'(Y_INIT);
      k_q       <= '0;
      iter_q    <= '0;
      blocked_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      k_q       <= k_d;
      iter_q    <= iter_d;
      blocked_q <= blocked_d;
    end
  end

  // FSM: next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (start) state_d = S_RUN;
      S_RUN: begin
        if (start) state_d = S_RUN;
        else if (step_apply && (iter_q == IW'(MAX_ITER - 1))) state_d = S_DONE;
      end
      S_DONE: if (start) state_d = S_RUN;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM: outputs and the invariant monitor.
  logic [W-1:0] x_exp, y_exp;
  always_comb begin
    busy    = (state_q == S_RUN);
    done    = (state_q == S_DONE);
    x       = x_q;
    y       = y_q;
    iter    = iter_q;
    blocked = blocked_q;
    // k*STEP in W-bit arithmetic is exactly the modulo-2^W displacement.
    x_exp   = W'(X_INIT) + k_q * W'(X_STEP);
    y_exp   = W'(Y_INIT) + k_q * W'(Y_STEP);
    inv_ok  = (x_q == x_exp) && (y_q == y_exp);
  end

endmodule
